uart8_transmitter_buffered: RTL and testbench

- 8-bit UART transmitter, 8N1 framing: one start bit, eight data bits LSB first, one stop bit.
- Counterpart of the team's 8-bit receiver. Runs on the same 16x-oversampled rx/tx clock, so one baud interval is OVERSAMPLE clk ticks.
- A one-deep holding register accepts the next byte while the current frame shifts out. Frames can therefore run back-to-back with no idle gap.

---
 rtl/uart8_transmitter_buffered_pkg.sv | 20 ++
 rtl/uart8_transmitter_buffered.sv | 145 ++++++++++++++
 tb/tb_uart8_transmitter_buffered.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart8_transmitter_buffered_pkg.sv
// Shared UART definitions: the state encoding used by both the 8-bit receiver
// and this transmitter, plus the common oversampling factor so the two sides
// cannot drift apart.
package uart8_transmitter_buffered_pkg;

    // Clock ticks per serial bit for both rx and tx.
    localparam int OVERSAMPLE_DEFAULT = 16;

    // 3-bit state encoding, identical to the receiver's. READY is kept only so
    // the encoding matches; the transmitter never enters it.
    typedef enum logic [2:0] {
        RESET     = 3'd0,
        IDLE      = 3'd1,
        START_BIT = 3'd2,
        DATA_BITS = 3'd3,
        STOP_BIT  = 3'd4,
        READY     = 3'd5
    } uart_state_t;

endpackage

// File: rtl/uart8_transmitter_buffered.sv
// 8N1 UART transmitter with a one-deep holding register. The next byte can be
// queued while the current frame shifts out, so frames run back-to-back with
// no idle gap on the line. One bit lasts OVERSAMPLE clk ticks.
module uart8_transmitter_buffered
    import uart8_transmitter_buffered_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       start,
    input  logic [7:0] in,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       out
);

    localparam int CW = $clog2(OVERSAMPLE);

    uart_state_t   state;
    logic [7:0]    hold;
    logic          hold_valid;
    logic [7:0]    shift;
    logic [2:0]    bit_index;
    logic [CW-1:0] sample_count;
    logic          sample_end;
    logic          accept;

    // Last tick of a bit interval; the counter wraps to zero on the next edge.
    assign sample_end = &sample_count;

    // NOTE: ready is the only combinational output. It must not depend on
    // start, otherwise an upstream handshake could form a combinational loop.
    assign ready  = en && !hold_valid && (state != RESET);
    assign accept = start && ready;

    // Holding register, shifter and frame sequencer in one registered block.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples the pre-edge values, regardless of statement order.
        if (reset) begin
            state        <= RESET;
            hold         <= '0;
            hold_valid   <= 1'b0;
            shift        <= '0;
            bit_index    <= '0;
            sample_count <= '0;
            out          <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (!en) begin
            // Disable aborts any frame and discards the queued byte.
            state        <= RESET;
            hold_valid   <= 1'b0;
            shift        <= '0;
            bit_index    <= '0;
            sample_count <= '0;
            out          <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;

            // Accept and drain never coincide: ready is low whenever hold is full.
            if (accept) begin
                hold       <= in;
                hold_valid <= 1'b1;
            end

            case (state)
                RESET: begin
                    out          <= 1'b1;
                    busy         <= 1'b0;
                    shift        <= '0;
                    bit_index    <= '0;
                    sample_count <= '0;
                    state        <= IDLE;
                end

                IDLE: begin
                    out  <= 1'b1;
                    busy <= 1'b0;
                    if (hold_valid) begin
                        shift        <= hold;
                        hold_valid   <= 1'b0;
                        out          <= 1'b0;
                        busy         <= 1'b1;
                        sample_count <= '0;
                        state        <= START_BIT;
                    end
                end

                START_BIT: begin
                    sample_count <= sample_count + 1'b1;
                    if (sample_end) begin
                        out          <= shift[0];
                        bit_index    <= 3'd1;
                        sample_count <= '0;
                        state        <= DATA_BITS;
                    end
                end

                DATA_BITS: begin
                    sample_count <= sample_count + 1'b1;
                    if (sample_end) begin
                        if (bit_index != 3'd0) begin
                            out       <= shift[bit_index];
                            bit_index <= bit_index + 3'd1;
                        end else begin
                            // bit_index wrapped: bit 7 has been held a full interval.
                            out   <= 1'b1;
                            state <= STOP_BIT;
                        end
                    end
                end

                STOP_BIT: begin
                    sample_count <= sample_count + 1'b1;
                    if (sample_end) begin
                        done <= 1'b1;
                        if (hold_valid) begin
                            // Back-to-back: next start bit begins with no gap.
                            shift      <= hold;
                            hold_valid <= 1'b0;
                            out        <= 1'b0;
                            state      <= START_BIT;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    out   <= 1'b1;
                    busy  <= 1'b0;
                    state <= RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart8_transmitter_buffered.sv
// Self-checking bench for uart8_transmitter_buffered. A frame-level model
// (time offset into a 10-bit frame plus a one-byte queue) predicts every
// output each cycle; a behavioural 16x receiver decodes the serial line.
module tb_uart8_transmitter_buffered;

    localparam int OS    = 16;
    localparam int FRAME = 10 * OS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       ready, busy, done, out_line;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int sb_prints = 0;

    uart8_transmitter_buffered #(.OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .start (start),
        .in    (in_data),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .out   (out_line)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- frame-level reference model ----------------
    typedef struct packed {
        logic       up;      // enabled and out of the reset state
        logic       active;  // a frame is on the line
        logic       hv;      // queued byte waiting
        logic       done;
        logic [8:0] t;       // clocks since the start-bit falling edge
        logic [7:0] cur;
        logic [7:0] hold;
    } model_t;

    model_t m = '0;
    logic [7:0] acc_q[$];

    function automatic model_t model_step(model_t s, logic e, logic st, logic [7:0] d);
        model_t n = s;
        logic   rdy;
        if (!e) return '0;
        if (!s.up) begin
            n = '0;
            n.up = 1'b1;
            return n;
        end
        rdy = !s.hv;
        n.done = 1'b0;
        if (s.active) begin
            n.t = s.t + 9'd1;
            if (int'(n.t) == FRAME) begin
                n.done = 1'b1;
                if (s.hv) begin
                    n.cur = s.hold;
                    n.hv  = 1'b0;
                    n.t   = '0;
                end else begin
                    n.active = 1'b0;
                end
            end
        end else if (s.hv) begin
            n.active = 1'b1;
            n.t      = '0;
            n.cur    = s.hold;
            n.hv     = 1'b0;
        end
        if (st && rdy) begin
            n.hold = d;
            n.hv   = 1'b1;
        end
        return n;
    endfunction

    // Line level for a given frame offset: start, 8 data LSB first, stop.
    function automatic logic exp_level(model_t s);
        int tt = int'(s.t);
        if (!s.active) return 1'b1;
        if (tt < OS) return 1'b0;
        if (tt < 9 * OS) return s.cur[(tt - OS) / OS];
        return 1'b1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= model_step(m, en, start, in_data);
    end

    always @(posedge clk) begin
        if (!reset && en && start && m.up && !m.hv) acc_q.push_back(in_data);
    end

    // Per-cycle scoreboard of {out, busy, done, ready}.
    always @(negedge clk) begin
        logic [3:0] act, exp;
        #1;
        act = {out_line, busy, done, ready};
        exp = {exp_level(m), m.active, m.done, en && m.up && !m.hv};
        n_total++;
        if (act !== exp) begin
            if (sb_prints < 10)
                $display("FAIL scoreboard cyc=%0d {out,busy,done,ready} got=%b want=%b", cyc, act, exp);
            sb_prints++;
        end else begin
            n_pass++;
        end
    end

    // ---------------- behavioural 16x receiver ----------------
    logic [7:0] rx_q[$];
    logic       rx_err_q[$];
    int         fall_q[$];
    int         done_q[$];

    initial begin : rx_monitor
        logic [7:0] d;
        logic       e;
        forever begin
            @(negedge clk);
            if (!reset && out_line === 1'b0) begin
                fall_q.push_back(cyc);
                repeat (OS / 2 - 1) @(negedge clk);
                e = (out_line !== 1'b0);
                for (int b = 0; b < 8; b++) begin
                    repeat (OS) @(negedge clk);
                    d[b] = out_line;
                end
                repeat (OS) @(negedge clk);
                e = e | (out_line !== 1'b1);
                rx_q.push_back(d);
                rx_err_q.push_back(e);
            end
        end
    end

    always @(negedge clk) if (done === 1'b1) done_q.push_back(cyc);

    // ---------------- stimulus helpers ----------------
    task automatic clear_logs();
        rx_q.delete();
        rx_err_q.delete();
        fall_q.delete();
        done_q.delete();
        acc_q.delete();
    endtask

    task automatic queue_byte(input logic [7:0] b);
        int waited = 0;
        while (ready !== 1'b1 && waited < 2 * FRAME) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2 * FRAME) begin
            n_total++;
            $display("FAIL queue_timeout byte=%h ready=%b want 1", b, ready);
        end
        start   = 1'b1;
        in_data = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int waited = 0;
        @(negedge clk);
        while (!(ready === 1'b1 && busy === 1'b0) && waited < 4 * FRAME) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 4 * FRAME) begin
            n_total++;
            $display("FAIL idle_timeout ready=%b busy=%b want 1/0", ready, busy);
        end
        repeat (OS) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_total++;
        if ({out_line, busy, done, ready} !== 4'b1000)
            $display("FAIL reset_outputs got=%b want=1000", {out_line, busy, done, ready});
        else n_pass++;
        en = 1'b1;
        #1;
        n_total++;
        if (ready !== 1'b0) $display("FAIL ready_in_reset got=%b want=0", ready); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if (ready !== 1'b0) $display("FAIL ready_before_idle got=%b want=0", ready); else n_pass++;
        @(negedge clk);
        n_total++;
        if ({ready, out_line} !== 2'b11) $display("FAIL idle_ready got=%b want=11", {ready, out_line}); else n_pass++;
    endtask

    task automatic test_single();
        clear_logs();
        queue_byte(8'hA5);
        wait_idle();
        n_total++;
        if (rx_q.size() !== 1 || rx_q[0] !== 8'hA5 || rx_err_q[0] !== 1'b0)
            $display("FAIL single_a5 rx_count=%0d byte=%h want 1 byte a5 err 0", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx);
        else n_pass++;
        n_total++;
        if (done_q.size() !== 1 || fall_q.size() !== 1 || done_q[0] - fall_q[0] !== FRAME)
            $display("FAIL single_done_time dones=%0d falls=%0d want one done %0d clks after fall", done_q.size(), fall_q.size(), FRAME);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_logs();
        queue_byte(8'h55);
        queue_byte(8'h0F);
        n_total++;
        if (busy !== 1'b1) $display("FAIL b2b_busy_at_queue got=%b want=1", busy); else n_pass++;
        wait_idle();
        n_total++;
        if (rx_q.size() !== 2 || rx_q[0] !== 8'h55 || rx_q[1] !== 8'h0F)
            $display("FAIL b2b_bytes count=%0d want 2 bytes 55 0f", rx_q.size());
        else n_pass++;
        n_total++;
        if (done_q.size() !== 2 || fall_q.size() !== 2 || done_q[1] - done_q[0] !== FRAME || fall_q[1] !== done_q[0])
            $display("FAIL b2b_timing dones=%0d falls=%0d want 2 dones %0d apart, no gap", done_q.size(), fall_q.size(), FRAME);
        else n_pass++;
    endtask

    task automatic test_hold_full();
        logic [7:0] a, b, c;
        a = 8'($urandom);
        b = 8'($urandom);
        c = ~b;
        clear_logs();
        queue_byte(a);
        queue_byte(b);
        n_total++;
        if ({ready, busy} !== 2'b01) $display("FAIL hold_full_ready got=%b want ready=0 busy=1", {ready, busy}); else n_pass++;
        start   = 1'b1;
        in_data = c;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_idle();
        n_total++;
        if (rx_q.size() !== 2 || rx_q[0] !== a || rx_q[1] !== b)
            $display("FAIL hold_full_bytes count=%0d want 2 bytes %h %h", rx_q.size(), a, b);
        else n_pass++;
        n_total++;
        if (done_q.size() !== 2) $display("FAIL hold_full_dones got=%0d want=2", done_q.size()); else n_pass++;
    endtask

    task automatic test_en_drop();
        clear_logs();
        queue_byte(8'hFF);
        queue_byte(8'h3C);
        n_total++;
        if (fall_q.size() < 1) begin
            $display("FAIL en_drop_no_fall falls=0 want 1");
        end else begin
            n_pass++;
            while (cyc < fall_q[0] + 70) @(negedge clk);
            n_total++;
            if (out_line !== 1'b1) $display("FAIL en_drop_bit3 got=%b want=1", out_line); else n_pass++;
            en = 1'b0;
            @(negedge clk);
            n_total++;
            if ({out_line, busy, done, ready} !== 4'b1000)
                $display("FAIL en_drop_outputs got=%b want=1000", {out_line, busy, done, ready});
            else n_pass++;
            repeat (5) @(negedge clk);
            n_total++;
            if (done_q.size() !== 0) $display("FAIL en_drop_no_done got=%0d want=0", done_q.size()); else n_pass++;
        end
        en = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        clear_logs();
        queue_byte(8'h00);
        wait_idle();
        n_total++;
        if (rx_q.size() !== 1 || rx_q[0] !== 8'h00 || rx_err_q[0] !== 1'b0)
            $display("FAIL en_drop_resume count=%0d want single byte 00 (3c discarded)", rx_q.size());
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [7:0] b0, b1;
        clear_logs();
        queue_byte(8'($urandom));
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({out_line, busy, done, ready} !== 4'b1000)
            $display("FAIL async_reset_outputs got=%b want=1000", {out_line, busy, done, ready});
        else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2 * FRAME) @(negedge clk);
        clear_logs();
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        queue_byte(b0);
        queue_byte(b1);
        wait_idle();
        n_total++;
        if (rx_q.size() !== 2 || rx_q[0] !== b0 || rx_q[1] !== b1 || rx_err_q[0] !== 1'b0 || rx_err_q[1] !== 1'b0)
            $display("FAIL async_reset_resume count=%0d want 2 bytes %h %h", rx_q.size(), b0, b1);
        else n_pass++;
    endtask

    task automatic test_loopback();
        logic [7:0] pat[4];
        pat = '{8'h00, 8'hFF, 8'h80, 8'h01};
        clear_logs();
        for (int i = 0; i < 4; i++) queue_byte(pat[i]);
        wait_idle();
        n_total++;
        if (rx_q.size() !== 4) $display("FAIL loopback_count got=%0d want=4", rx_q.size()); else n_pass++;
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            n_total++;
            if (rx_q[i] !== pat[i] || rx_err_q[i] !== 1'b0)
                $display("FAIL loopback_byte%0d got=%h err=%b want=%h err=0", i, rx_q[i], rx_err_q[i], pat[i]);
            else n_pass++;
        end
        n_total++;
        if (done_q.size() !== 4 || done_q[3] - done_q[0] !== 3 * FRAME)
            $display("FAIL loopback_dones count=%0d want 4 dones spaced %0d", done_q.size(), FRAME);
        else n_pass++;
    endtask

    task automatic test_random();
        clear_logs();
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 200)) @(negedge clk);
            start   = 1'b1;
            in_data = 8'($urandom);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
        n_total++;
        if (rx_q.size() !== acc_q.size() || acc_q.size() == 0)
            $display("FAIL random_count got=%0d want=%0d (nonzero)", rx_q.size(), acc_q.size());
        else n_pass++;
        for (int i = 0; i < acc_q.size() && i < rx_q.size(); i++) begin
            n_total++;
            if (rx_q[i] !== acc_q[i] || rx_err_q[i] !== 1'b0)
                $display("FAIL random_byte%0d got=%h err=%b want=%h err=0", i, rx_q[i], rx_err_q[i], acc_q[i]);
            else n_pass++;
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_full();
        test_en_drop();
        test_async_reset();
        test_loopback();
        test_random();
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
